md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the execute stage, directly upstream of the GPR write port.
- Its rd output feeds GPR Din for MFHI/MFLO.
- busy tells the hazard unit to stall any MD instruction that arrives while an operation is in flight.

Parameters:
- MUL_CYCLES, 5, cycles from accept to HI/LO update for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, cycles from accept to HI/LO update for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; qualifies op for one cycle.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6..7 reserved, treated as no-op.
- A  in  32  operand rs.
- B  in  32  operand rt.
- rd_sel  in  1  0 selects LO, 1 selects HI on rd.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO are updated by MULT/DIV.
- rd  out  32  combinational read of HI or LO, to GPR Din.

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0.
  - A reset mid-operation aborts it; HI/LO read 0 afterwards.
- States:
  - IDLE: busy=0. On start with op 0..3, latch the operands, compute the result into internal res_hi/res_lo, load counter with MUL_CYCLES or DIV_CYCLES, go to RUN.
  - RUN: busy=1; counter decrements each cycle. When counter reaches 1, the next edge writes HI/LO from res_hi/res_lo, pulses done, and returns to IDLE.
- Latency: start accepted at edge N means HI/LO are visible at edge N+CYCLES and busy is low from that edge.
- busy rises at the accepting edge; there is no combinational path from start to busy.
- MTHI/MTLO:
  - Accepted only in IDLE.
  - A written to HI or LO at the same edge; single cycle; no busy, no done.
- start while busy: ignored entirely; HI/LO and counter unaffected. The stall logic must prevent this.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32 to 64; same split.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divide by zero: LO=32'hFFFF_FFFF, HI=A.
  - Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- rd: combinational; returns the current HI/LO register, never the pending result. A read during busy returns the old value.

Optional Feature:
- MD_FLAG_EN defined:
  - Adds outputs FlagOp[1:0] and NFlag[31:0], connecting to the GPR flag register port.
  - On completion of DIV/DIVU with B==0, in the done cycle: FlagOp=FLAG_OP_SET, NFlag=32'h0000_0001.
  - On any other completion: FlagOp=FLAG_OP_SET, NFlag=0.
  - Otherwise FlagOp=FLAG_OP_DIS.
  - Reset value: FlagOp=FLAG_OP_DIS, NFlag=0.
- Not defined: ports absent; no flag activity.

Decomposition:
- MD op encodings (MD_OP_MULT..MD_OP_MTLO) go in the shared macro header.
- FLAG_OP_DIS/SET are reused from that header, not redefined.
- One natural sub-module, md_div_core: combinational signed/unsigned divide with the zero and overflow rules.
- Multiply stays inline.

Test Plan:
- Reset then rd_sel=0/1 -> rd=0 both; busy=0. Assert reset low during RUN of a DIV -> busy=0 immediately; HI=LO=0.
- MULT A=32'hFFFF_FFFE (-2), B=3 -> busy high for 5 cycles, done pulse at edge N+5; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. Read during busy returns the prior values.
- DIVU A=100, B=7 -> LO=14, HI=2 at edge N+10. DIV A=-7, B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIV A=32'h8000_0000, B=32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0. DIV A=5, B=0 -> LO=32'hFFFF_FFFF, HI=5; with MD_FLAG_EN, NFlag=1 and FlagOp=SET in the done cycle only.
- MTHI A=32'h1234_5678 then MTLO A=32'h9ABC_DEF0 -> HI/LO updated next edge; busy never high.
- Second start (MULTU A=2, B=2) issued during busy -> ignored; HI/LO hold the first operation's result; done pulses once.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: MD opcodes, GPR flag-port ops, FSM state type.
package md_unit_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   localparam logic [1:0] FLAG_OP_DIS = 2'd0;
   localparam logic [1:0] FLAG_OP_SET = 2'd1;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divider, signed or unsigned, with the divide-by-zero and INT_MIN/-1 rules.
module md_div_core
   import md_unit_pkg::*;
(
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        is_signed,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        neg_dvd;
   logic        neg_dvs;
   logic [31:0] mag_dvd;
   logic [31:0] mag_dvs;
   logic [31:0] mag_q;
   logic [31:0] mag_r;

   // One unsigned divider on magnitudes; signs are reapplied afterwards.
   always_comb begin
      neg_dvd = is_signed & dividend[31];
      neg_dvs = is_signed & divisor[31];
      mag_dvd = neg_dvd ? (~dividend + 32'd1) : dividend;
      mag_dvs = neg_dvs ? (~divisor + 32'd1) : divisor;
      mag_q   = '0;
      mag_r   = '0;
      if (mag_dvs != 32'd0) begin
         mag_q = mag_dvd / mag_dvs;
         mag_r = mag_dvd % mag_dvs;
      end
      if (divisor == 32'd0) begin
         quotient  = 32'hFFFF_FFFF;
         remainder = dividend;
      end else if (is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF)) begin
         quotient  = 32'h8000_0000;
         remainder = 32'd0;
      end else begin
         quotient  = (neg_dvd ^ neg_dvs) ? (~mag_q + 32'd1) : mag_q;
         remainder = neg_dvd ? (~mag_r + 32'd1) : mag_r;
      end
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers feeding GPR Din.
// Define MD_FLAG_EN to add the FlagOp/NFlag outputs to the GPR flag register port.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        rd_sel,
   output logic        busy,
   output logic        done,
   output logic [31:0] rd
`ifdef MD_FLAG_EN
   ,
   output logic [1:0]  FlagOp,
   output logic [31:0] NFlag
`endif
);

   localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
   localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] div_quo;
   logic [31:0] div_rem;
   logic        accept_arith;
   logic        finishing;

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};

   md_div_core u_div (
      .dividend (A),
      .divisor  (B),
      .is_signed(op == MD_OP_DIV),
      .quotient (div_quo),
      .remainder(div_rem)
   );

   assign accept_arith = (state_q == MD_IDLE) && start && (op <= MD_OP_DIVU);
   assign finishing    = (state_q == MD_RUN) && (cnt_q <= 4'd1);

   // The result is computed at accept and parked in res_hi/res_lo until the countdown expires.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               case (op)
                  MD_OP_MULT: begin
                     res_hi_d = prod_s[63:32];
                     res_lo_d = prod_s[31:0];
                     cnt_d    = MUL_CNT;
                     state_d  = MD_RUN;
                     busy_d   = 1'b1;
                  end
                  MD_OP_MULTU: begin
                     res_hi_d = prod_u[63:32];
                     res_lo_d = prod_u[31:0];
                     cnt_d    = MUL_CNT;
                     state_d  = MD_RUN;
                     busy_d   = 1'b1;
                  end
                  MD_OP_DIV, MD_OP_DIVU: begin
                     res_hi_d = div_rem;
                     res_lo_d = div_quo;
                     cnt_d    = DIV_CNT;
                     state_d  = MD_RUN;
                     busy_d   = 1'b1;
                  end
                  MD_OP_MTHI: hi_d = A;
                  MD_OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         MD_RUN: begin
            if (finishing) begin
               hi_d    = res_hi_q;
               lo_d    = res_lo_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = 4'd0;
               state_d = MD_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = MD_IDLE;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= MD_IDLE;
         cnt_q    <= 4'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign rd   = rd_sel ? hi_q : lo_q;

`ifdef MD_FLAG_EN
   logic        dz_q, dz_d;
   logic [1:0]  flag_op_q, flag_op_d;
   logic [31:0] nflag_q, nflag_d;

   // Divide-by-zero is remembered from accept so the flag lands in the same cycle as done.
   always_comb begin
      dz_d      = dz_q;
      flag_op_d = FLAG_OP_DIS;
      nflag_d   = 32'd0;
      if (accept_arith) begin
         dz_d = md_is_div(op) && (B == 32'd0);
      end
      if (finishing) begin
         flag_op_d = FLAG_OP_SET;
         nflag_d   = {31'd0, dz_q};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dz_q      <= 1'b0;
         flag_op_q <= FLAG_OP_DIS;
         nflag_q   <= 32'd0;
      end else begin
         dz_q      <= dz_d;
         flag_op_q <= flag_op_d;
         nflag_q   <= nflag_d;
      end
   end

   assign FlagOp = flag_op_q;
   assign NFlag  = nflag_q;
`endif

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: timestamp-based reference model plus directed literal checks.
module tb_md_unit;
   import md_unit_pkg::*;

   localparam int MUL_C = 5;
   localparam int DIV_C = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        rd_sel;
   logic        busy;
   logic        done;
   logic [31:0] rd;
`ifdef MD_FLAG_EN
   logic [1:0]  flag_op;
   logic [31:0] nflag;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   md_unit #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (a_in),
      .B     (b_in),
      .rd_sel(rd_sel),
      .busy  (busy),
      .done  (done),
      .rd    (rd)
`ifdef MD_FLAG_EN
      ,
      .FlagOp(flag_op),
      .NFlag (nflag)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Reference arithmetic straight from the opcode definitions, returned as {HI, LO}.
   function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      int              qa, qb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      qa = $signed(a);
      qb = $signed(b);
      case (o)
         3'd0: return 64'(sa * sb);
         3'd1: return 64'(ua * ub);
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(qa % qb), 32'(qa / qb)};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
   int          cyc = 0;
   int          m_done_at = 0;

   // Model and compare at every edge; the result appears exactly CYCLES edges after acceptance.
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      end else begin
         cyc    = cyc + 1;
         m_done = 1'b0;
         if (m_busy) begin
            if (cyc == m_done_at) begin
               m_hi   = p_hi;
               m_lo   = p_lo;
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (start) begin
            if (op <= 3'd3) begin
               {p_hi, p_lo} = ref_calc(op, a_in, b_in);
               m_done_at    = cyc + ((op <= 3'd1) ? MUL_C : DIV_C);
               m_busy       = 1'b1;
               m_dz         = (op >= 3'd2) && (b_in == 32'd0);
            end else if (op == 3'd4) begin
               m_hi = a_in;
            end else if (op == 3'd5) begin
               m_lo = a_in;
            end
         end
      end
      check_output("model_busy", {31'd0, busy}, {31'd0, m_busy});
      check_output("model_done", {31'd0, done}, {31'd0, m_done});
      check_output("model_rd", rd, rd_sel ? m_hi : m_lo);
`ifdef MD_FLAG_EN
      check_output("model_flagop", {30'd0, flag_op}, {30'd0, m_done ? FLAG_OP_SET : FLAG_OP_DIS});
      check_output("model_nflag", nflag, {31'd0, m_done & m_dz});
`endif
   end

   task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #2;
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cycles = i;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_done timeout after %0d cycles", budget);
   endtask

   task automatic check_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      rd_sel = 1'b0;
      #1;
      check_output({name, "_lo"}, rd, exp_lo);
      rd_sel = 1'b1;
      #1;
      check_output({name, "_hi"}, rd, exp_hi);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      int pulses;
      reset  = 1'b0;
      start  = 1'b0;
      op     = 3'd0;
      a_in   = '0;
      b_in   = '0;
      rd_sel = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_hilo("reset", 32'd0, 32'd0);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;

      apply_stimulus(MD_OP_MTHI, 32'h1234_5678, 32'd0);
      check_hilo("mthi", 32'h1234_5678, 32'd0);
      apply_stimulus(MD_OP_MTLO, 32'h9ABC_DEF0, 32'd0);
      check_hilo("mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

      apply_stimulus(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3);
      check_output("mult_busy", {31'd0, busy}, 32'd1);
      check_hilo("mult_old", 32'h1234_5678, 32'h9ABC_DEF0);
      wait_done(20, lat);
      check_output("mult_latency", 32'(lat), 32'(MUL_C));
      check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      apply_stimulus(MD_OP_DIVU, 32'd100, 32'd7);
      wait_done(20, lat);
      check_output("divu_latency", 32'(lat), 32'(DIV_C));
      check_hilo("divu", 32'd2, 32'd14);

      apply_stimulus(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(20, lat);
      check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      apply_stimulus(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(20, lat);
      check_hilo("div_ovf", 32'd0, 32'h8000_0000);

      apply_stimulus(MD_OP_DIV, 32'd5, 32'd0);
      wait_done(20, lat);
`ifdef MD_FLAG_EN
      check_output("dz_flagop", {30'd0, flag_op}, {30'd0, FLAG_OP_SET});
      check_output("dz_nflag", nflag, 32'd1);
`endif
      check_hilo("div_zero", 32'd5, 32'hFFFF_FFFF);
`ifdef MD_FLAG_EN
      @(posedge clk);
      #1;
      check_output("dz_flagop_after", {30'd0, flag_op}, {30'd0, FLAG_OP_DIS});
      check_output("dz_nflag_after", nflag, 32'd0);
`endif

      apply_stimulus(MD_OP_MULT, 32'd3, 32'd4);
      apply_stimulus(MD_OP_MULTU, 32'd2, 32'd2);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check_output("double_start_pulses", 32'(pulses), 32'd1);
      check_hilo("double_start", 32'd0, 32'd12);

      apply_stimulus(MD_OP_DIV, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_output("abort_busy", {31'd0, busy}, 32'd0);
      check_output("abort_done", {31'd0, done}, 32'd0);
      check_hilo("abort", 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      repeat (15) @(posedge clk);

      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #2;
         start  = ($urandom_range(0, 2) == 0);
         op     = 3'($urandom_range(0, 7));
         a_in   = pick_operand();
         b_in   = pick_operand();
         rd_sel = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #2;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #2;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
